// File: rtl/cpu_pkg.sv
// Shared definitions for the pipelined LEGv8 core: datapath widths, fetch FSM
// encoding, the canonical NOP and the fetch-stage debug bundle.
package cpu_pkg;

  localparam int ADDR_W  = 64;
  localparam int INSTR_W = 32;

  // A64 NOP encoding, used to fill IF/ID when a bubble is loaded.
  localparam logic [INSTR_W-1:0] INSTR_NOP = 32'hD503_201F;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    fetch_state_t state;
    logic         hold_valid;
  } fetch_dbg_t;

  function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Single-entry skid register holding one fetched {pc, instr} pair while decode
// is stalled. Load takes priority over clear.
module fetch_hold_buf
  import cpu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               clear_i,
  input  logic [ADDR_W-1:0]  pc_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               valid_o,
  output logic [ADDR_W-1:0]  pc_o,
  output logic [INSTR_W-1:0] instr_o
);

  logic               valid_q, valid_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      instr_d = instr_i;
    end else if (clear_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign instr_o = instr_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the PC register's next value, issues
// instruction-memory requests and fills the IF/ID register for decode.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc_q,
  output logic [ADDR_W-1:0]  pc_d,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               br_taken,
  input  logic [ADDR_W-1:0]  br_target,
  input  logic               stall,
  output logic               if_valid,
  output logic [ADDR_W-1:0]  if_pc,
  output logic [INSTR_W-1:0] if_instr,
  output fetch_dbg_t         dbg_o
);

  // Memory handshake: imem_req acts as valid and imem_ack as ready. Once
  // imem_req rises, it and imem_addr stay stable until the cycle imem_ack is
  // seen (ack may coincide with the first req cycle); a request is never
  // withdrawn, so a redirect with a request in flight parks in S_DROP.

  fetch_state_t       state_q, state_d;
  logic               if_valid_q, if_valid_d;
  logic [ADDR_W-1:0]  if_pc_q, if_pc_d;
  logic [INSTR_W-1:0] if_instr_q, if_instr_d;
  logic [ADDR_W-1:0]  drop_addr_q, drop_addr_d;

  logic               hold_load, hold_clear, hold_valid;
  logic [ADDR_W-1:0]  hold_pc;
  logic [INSTR_W-1:0] hold_instr;

  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  br_addr;

  assign pc_inc  = pc_q + ADDR_W'(4);
  assign br_addr = align_word(br_target);

  fetch_hold_buf u_hold_buf (
    .clk     (clk),
    .rst_n   (reset),
    .load_i  (hold_load),
    .clear_i (hold_clear),
    .pc_i    (pc_q),
    .instr_i (imem_rdata),
    .valid_o (hold_valid),
    .pc_o    (hold_pc),
    .instr_o (hold_instr)
  );

  always_comb begin
    state_d     = state_q;
    if_valid_d  = if_valid_q;
    if_pc_d     = if_pc_q;
    if_instr_d  = if_instr_q;
    drop_addr_d = drop_addr_q;
    hold_load   = 1'b0;
    hold_clear  = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    pc_d        = pc_q;

    case (state_q)
      S_REQ: begin
        imem_req = 1'b1;
        if (br_taken) begin
          pc_d = br_addr;
          if (!imem_ack) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (imem_ack) begin
          pc_d = pc_inc;
          if (stall) begin
            hold_load = 1'b1;
            state_d   = S_HOLD;
          end else begin
            if_valid_d = 1'b1;
            if_pc_d    = pc_q;
            if_instr_d = imem_rdata;
          end
        end else if (!stall) begin
          if_valid_d = 1'b0;
          if_instr_d = INSTR_NOP;
        end
      end

      S_HOLD: begin
        if (br_taken) begin
          pc_d       = br_addr;
          hold_clear = 1'b1;
          state_d    = S_REQ;
        end else if (!stall) begin
          if_valid_d = hold_valid;
          if_pc_d    = hold_pc;
          if_instr_d = hold_instr;
          hold_clear = 1'b1;
          state_d    = S_REQ;
        end
      end

      S_DROP: begin
        imem_req  = 1'b1;
        imem_addr = drop_addr_q;
        if (br_taken) begin
          pc_d = br_addr;
        end
        if (imem_ack) begin
          state_d = S_REQ;
        end
        if (!br_taken && !stall) begin
          if_valid_d = 1'b0;
          if_instr_d = INSTR_NOP;
        end
      end

      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect flushes IF/ID regardless of stall.
    if (br_taken) begin
      if_valid_d = 1'b0;
    end

    if (!reset) begin
      pc_d     = RESET_PC;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_REQ;
      if_valid_q  <= 1'b0;
      if_pc_q     <= '0;
      if_instr_q  <= '0;
      drop_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      if_valid_q  <= if_valid_d;
      if_pc_q     <= if_pc_d;
      if_instr_q  <= if_instr_d;
      drop_addr_q <= drop_addr_d;
    end
  end

  assign if_valid         = if_valid_q;
  assign if_pc            = if_pc_q;
  assign if_instr         = if_instr_q;
  assign dbg_o.state      = state_q;
  assign dbg_o.hold_valid = hold_valid;

endmodule
